// File: rtl/dma_timing_control.sv
// Transfer-cycle sequencer for an 8237A-style DMA controller: HRQ/HLDA handshake,
// SI..S4 state sequence, bus strobes and the per-transfer address/count update pulse.
module dma_timing_control #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [NUM_CH-1:0] valid_dreq,
    input  logic [NUM_CH-1:0] grant,
    input  logic              ctrl_disable,
    input  logic [1:0]        xfer_mode,
    input  logic [1:0]        xfer_type,
    input  logic              HLDA,
    input  logic              READY,
    input  logic              tc,
    input  logic              EOP_N_in,
    output logic              hrq,
    output logic              valid_dack,
    output logic [CH_W-1:0]   active_ch,
    output logic              aen,
    output logic              adstb,
    output logic              MEMR_N,
    output logic              MEMW_N,
    output logic              IOR_N,
    output logic              IOW_N,
    output logic              EOP_N_out,
    output logic              update
);

    typedef enum logic [2:0] {SI, S0, S1, S2, S3, SW, S4} state_e;

    localparam logic [1:0] MODE_DEMAND = 2'b00;
    localparam logic [1:0] MODE_BLOCK  = 2'b10;
    localparam logic [1:0] TYPE_WRITE  = 2'b01;
    localparam logic [1:0] TYPE_READ   = 2'b10;

    state_e          state_q, state_d;
    logic [CH_W-1:0] active_ch_q, active_ch_d;
    logic            eop_latch_q, eop_latch_d;
    logic            hrq_q, hrq_d, aen_q, aen_d, adstb_q, adstb_d;
    logic            dack_q, dack_d, update_q, update_d;
    logic            memr_n_q, memr_n_d, memw_n_q, memw_n_d;
    logic            ior_n_q, ior_n_d, iow_n_q, iow_n_d;
    logic            rd_act, wr_act;
    logic [CH_W-1:0] grant_enc;

    // One-hot to binary: each encoded bit ORs the grant lines whose index has that bit set.
    genvar gi, gj;
    generate
        for (gi = 0; gi < CH_W; gi++) begin : g_enc
            logic [NUM_CH-1:0] hit;
            for (gj = 0; gj < NUM_CH; gj++) begin : g_bit
                localparam logic [31:0] IDX = gj;
                assign hit[gj] = grant[gj] & IDX[gi];
            end
            assign grant_enc[gi] = |hit;
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= SI;
            active_ch_q <= '0;
            eop_latch_q <= 1'b0;
            hrq_q       <= 1'b0;
            aen_q       <= 1'b0;
            adstb_q     <= 1'b0;
            dack_q      <= 1'b0;
            update_q    <= 1'b0;
            memr_n_q    <= 1'b1;
            memw_n_q    <= 1'b1;
            ior_n_q     <= 1'b1;
            iow_n_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            active_ch_q <= active_ch_d;
            eop_latch_q <= eop_latch_d;
            hrq_q       <= hrq_d;
            aen_q       <= aen_d;
            adstb_q     <= adstb_d;
            dack_q      <= dack_d;
            update_q    <= update_d;
            memr_n_q    <= memr_n_d;
            memw_n_q    <= memw_n_d;
            ior_n_q     <= ior_n_d;
            iow_n_q     <= iow_n_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        active_ch_d = active_ch_q;
        eop_latch_d = eop_latch_q;
        case (state_q)
            SI: begin
                if (!ctrl_disable && |valid_dreq) begin
                    active_ch_d = grant_enc;
                    state_d     = S0;
                end
            end
            S0: begin
                if (HLDA)
                    state_d = S1;
                else if (!valid_dreq[active_ch_q])
                    state_d = SI;
            end
            S1, S2: begin
                state_d = (state_q == S1) ? S2 : S3;
                if (!EOP_N_in)
                    eop_latch_d = 1'b1;
            end
            S3, SW: begin
                state_d = READY ? S4 : SW;
                if (!EOP_N_in)
                    eop_latch_d = 1'b1;
            end
            S4: begin
                eop_latch_d = 1'b0;
                if (tc || eop_latch_q || !HLDA)
                    state_d = SI;
                else if (xfer_mode == MODE_BLOCK)
                    state_d = S1;
                else if (xfer_mode == MODE_DEMAND)
                    state_d = valid_dreq[active_ch_q] ? S1 : SI;
                else
                    state_d = SI;
            end
            default: state_d = SI;
        endcase
    end

    // Outputs are decoded from the next state so every strobe leaves a flop glitch-free.
    always_comb begin
        rd_act   = state_d inside {S2, S3, SW};
        wr_act   = state_d inside {S3, SW};
        hrq_d    = (state_d != SI);
        aen_d    = state_d inside {S1, S2, S3, SW, S4};
        adstb_d  = (state_d == S1);
        dack_d   = state_d inside {S2, S3, SW, S4};
        update_d = (state_d == S4);
        memr_n_d = !(rd_act && xfer_type == TYPE_READ);
        ior_n_d  = !(rd_act && xfer_type == TYPE_WRITE);
        iow_n_d  = !(wr_act && xfer_type == TYPE_READ);
        memw_n_d = !(wr_act && xfer_type == TYPE_WRITE);
    end

    assign hrq        = hrq_q;
    assign aen        = aen_q;
    assign adstb      = adstb_q;
    assign valid_dack = dack_q;
    assign update     = update_q;
    assign active_ch  = active_ch_q;
    assign MEMR_N     = memr_n_q;
    assign MEMW_N     = memw_n_q;
    assign IOR_N      = ior_n_q;
    assign IOW_N      = iow_n_q;
    // tc is only valid while in S4, so end-of-process follows it within the same cycle.
    assign EOP_N_out  = !((state_q == S4) && (tc || eop_latch_q));

endmodule

// File: tb/tb_dma_timing_control.sv
// Bench for dma_timing_control: each transaction is expanded into a cycle-by-cycle plan of
// inputs and expected outputs from the S0..S4 sequencing rules, then replayed and compared.
module tb_dma_timing_control;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] valid_dreq, grant;
    logic       ctrl_disable, HLDA, READY, tc, EOP_N_in;
    logic [1:0] xfer_mode, xfer_type;
    logic       hrq, valid_dack, aen, adstb, MEMR_N, MEMW_N, IOR_N, IOW_N, EOP_N_out, update;
    logic [1:0] active_ch;

    always #5 CLK = ~CLK;

    dma_timing_control #(.NUM_CH(4), .CH_W(2)) dut (
        .CLK(CLK), .RESET(RESET), .valid_dreq(valid_dreq), .grant(grant),
        .ctrl_disable(ctrl_disable), .xfer_mode(xfer_mode), .xfer_type(xfer_type),
        .HLDA(HLDA), .READY(READY), .tc(tc), .EOP_N_in(EOP_N_in),
        .hrq(hrq), .valid_dack(valid_dack), .active_ch(active_ch), .aen(aen), .adstb(adstb),
        .MEMR_N(MEMR_N), .MEMW_N(MEMW_N), .IOR_N(IOR_N), .IOW_N(IOW_N),
        .EOP_N_out(EOP_N_out), .update(update)
    );

    typedef enum int {P_SI, P_S0, P_S1, P_S2, P_S3, P_SW, P_S4} phase_e;

    typedef struct {
        phase_e      ph;
        logic        rst;
        logic [3:0]  dreq;
        logic [3:0]  grant;
        logic        dis;
        logic [1:0]  mode;
        logic [1:0]  xtype;
        logic        hlda;
        logic        ready;
        logic        tc;
        logic        eop_n;
        logic [11:0] exp;
    } cyc_t;

    cyc_t       plan[$];
    int         checks = 0;
    int         errors = 0;
    int         exp_updates = 0;
    logic [1:0] m_ch;
    logic [1:0] s_mode, s_type;

    function automatic logic [3:0] rnd4();
        return 4'($urandom);
    endfunction

    function automatic logic rnd1();
        return 1'($urandom);
    endfunction

    function automatic string phase_str(phase_e ph);
        case (ph)
            P_SI: return "SI";
            P_S0: return "S0";
            P_S1: return "S1";
            P_S2: return "S2";
            P_S3: return "S3";
            P_SW: return "SW";
            default: return "S4";
        endcase
    endfunction

    // {hrq, aen, adstb, dack, active_ch, MEMR_N, MEMW_N, IOR_N, IOW_N, EOP_N_out, update}
    function automatic logic [11:0] obs_vec();
        return {hrq, aen, adstb, valid_dack, active_ch, MEMR_N, MEMW_N, IOR_N, IOW_N, EOP_N_out, update};
    endfunction

    function automatic logic [11:0] expect_vec(phase_e ph, logic [1:0] ch, logic [1:0] xt, logic eop_low);
        logic in_bus, rd, wr;
        in_bus = (ph == P_S1 || ph == P_S2 || ph == P_S3 || ph == P_SW || ph == P_S4);
        rd     = (ph == P_S2 || ph == P_S3 || ph == P_SW);
        wr     = (ph == P_S3 || ph == P_SW);
        return {ph != P_SI, in_bus, ph == P_S1, in_bus && ph != P_S1, ch,
                !(rd && xt == 2'b10), !(wr && xt == 2'b01), !(rd && xt == 2'b01), !(wr && xt == 2'b10),
                !eop_low, ph == P_S4};
    endfunction

    task automatic add(input phase_e ph, input logic rst, input logic [3:0] dreq, input logic [3:0] gnt,
                       input logic dis, input logic hlda, input logic ready, input logic tcv,
                       input logic eop_n, input logic eop_low);
        cyc_t c;
        c.ph = ph; c.rst = rst; c.dreq = dreq; c.grant = gnt; c.dis = dis;
        c.mode = s_mode; c.xtype = s_type; c.hlda = hlda; c.ready = ready; c.tc = tcv; c.eop_n = eop_n;
        c.exp = expect_vec(ph, m_ch, s_type, eop_low);
        plan.push_back(c);
        if (ph == P_S4) exp_updates++;
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) add(P_SI, 1'b0, 4'b0, rnd4(), rnd1(), 1'b0, rnd1(), rnd1(), 1'b1, 1'b0);
    endtask

    task automatic run_plan(input string name);
        int          ups;
        logic [11:0] obs;
        ups = 0;
        foreach (plan[i]) begin
            @(negedge CLK);
            RESET = plan[i].rst; valid_dreq = plan[i].dreq; grant = plan[i].grant;
            ctrl_disable = plan[i].dis; xfer_mode = plan[i].mode; xfer_type = plan[i].xtype;
            HLDA = plan[i].hlda; READY = plan[i].ready; tc = plan[i].tc; EOP_N_in = plan[i].eop_n;
            #1;
            obs = obs_vec();
            checks++;
            assert (obs === plan[i].exp) else begin
                errors++;
                $error("FAIL %s cyc %0d phase %s outputs=%h expected=%h", name, i, phase_str(plan[i].ph), obs, plan[i].exp);
            end
            if (update === 1'b1) ups++;
        end
        checks++;
        assert (ups == exp_updates) else begin
            errors++;
            $error("FAIL %s update_count got=%0d expected=%0d", name, ups, exp_updates);
        end
        $display("%s: ch=%0d mode=%b type=%b cycles=%0d updates=%0d", name, m_ch, s_mode, s_type, plan.size(), ups);
        plan.delete();
        exp_updates = 0;
    endtask

    // One service from request to return to SI; negative pass numbers mean "never".
    task automatic run_scn(input string name, input int ch, input logic [1:0] mode, input logic [1:0] xt,
                           input int hdly, input int tc_pass, input int eop_pass, input int drop_pass,
                           input int hloss_pass, input bit s0_abort, input bit rst_s3, input int w_first);
        logic [3:0] bit_m, dq;
        logic       hl, eop_p, tc_p, drop_p;
        int         w;
        bit_m = 4'(1 << ch);
        s_mode = mode; s_type = xt;
        add_idle(1);
        dq = bit_m | (rnd4() & ~bit_m);
        add(P_SI, 1'b0, dq, bit_m, 1'b0, 1'b0, 1'b1, rnd1(), 1'b1, 1'b0);
        m_ch = 2'(ch);
        for (int i = 0; i < hdly; i++) add(P_S0, 1'b0, dq, rnd4(), rnd1(), 1'b0, rnd1(), rnd1(), 1'b1, 1'b0);
        if (s0_abort) begin
            add(P_S0, 1'b0, dq & ~bit_m, rnd4(), rnd1(), 1'b0, rnd1(), rnd1(), 1'b1, 1'b0);
            add_idle(2);
            run_plan(name);
            return;
        end
        add(P_S0, 1'b0, dq, rnd4(), rnd1(), 1'b1, rnd1(), rnd1(), 1'b1, 1'b0);
        hl = 1'b1;
        for (int p = 0; p < 8; p++) begin
            eop_p  = (p == eop_pass);
            tc_p   = (p == tc_pass);
            drop_p = (mode == 2'b00) && (p == drop_pass);
            add(P_S1, 1'b0, dq, rnd4(), rnd1(), hl, rnd1(), rnd1(), 1'b1, 1'b0);
            if (p == hloss_pass) hl = 1'b0;
            add(P_S2, 1'b0, dq, rnd4(), rnd1(), hl, rnd1(), rnd1(), !eop_p, 1'b0);
            if (rst_s3) begin
                add(P_S3, 1'b1, dq, rnd4(), rnd1(), hl, 1'b1, 1'b0, 1'b1, 1'b0);
                m_ch = 2'd0;
                break;
            end
            w = (p == 0 && w_first >= 0) ? w_first : int'($urandom_range(0, 2));
            add(P_S3, 1'b0, dq, rnd4(), rnd1(), hl, w == 0, rnd1(), 1'b1, 1'b0);
            for (int j = 1; j <= w; j++) add(P_SW, 1'b0, dq, rnd4(), rnd1(), hl, j == w, rnd1(), 1'b1, 1'b0);
            if (drop_p) dq = dq & ~bit_m;
            add(P_S4, 1'b0, dq, rnd4(), rnd1(), hl, rnd1(), tc_p, 1'b1, tc_p || eop_p);
            if (tc_p || eop_p || !hl || mode == 2'b01 || mode == 2'b11 || drop_p) break;
        end
        add_idle(2);
        run_plan(name);
    endtask

    task automatic run_disabled(input string name);
        s_mode = 2'b01; s_type = 2'b10;
        for (int i = 0; i < 6; i++) add(P_SI, 1'b0, rnd4() | 4'b0100, rnd4(), 1'b1, rnd1(), 1'b1, rnd1(), 1'b1, 1'b0);
        add_idle(1);
        run_plan(name);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ch, hdly, tcp, eopp, dropp, hlp;
        logic [1:0] md, xt;
        bit ab;
        RESET = 1'b1; valid_dreq = '0; grant = '0; ctrl_disable = 1'b0; xfer_mode = 2'b00;
        xfer_type = 2'b00; HLDA = 1'b0; READY = 1'b1; tc = 1'b0; EOP_N_in = 1'b1;
        m_ch = 2'd0; s_mode = 2'b00; s_type = 2'b00;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++;
        assert (obs_vec() === 12'h03E) else begin
            errors++;
            $error("FAIL reset_state outputs=%h expected=%h", obs_vec(), 12'h03E);
        end
        RESET = 1'b0;

        run_scn("single_read_ch2",    2, 2'b01, 2'b10, 2, -1, -1, -1, -1, 1'b0, 1'b0, 0);
        run_scn("block_write_ch0_tc", 0, 2'b10, 2'b01, 0,  2, -1, -1, -1, 1'b0, 1'b0, 0);
        run_scn("wait_states_ch1",    1, 2'b01, 2'b10, 1, -1, -1, -1, -1, 1'b0, 1'b0, 3);
        run_scn("demand_drop_ch1",    1, 2'b00, 2'b10, 0, -1, -1,  1, -1, 1'b0, 1'b0, 0);
        run_scn("block_eop_ch3",      3, 2'b10, 2'b10, 0,  3,  0, -1, -1, 1'b0, 1'b0, 0);
        run_scn("reset_in_s3",        2, 2'b01, 2'b10, 0, -1, -1, -1, -1, 1'b0, 1'b1, 0);
        run_scn("s0_request_drop",    1, 2'b01, 2'b10, 2, -1, -1, -1, -1, 1'b1, 1'b0, 0);
        run_disabled("ctrl_disabled");
        run_scn("block_hlda_loss",    0, 2'b10, 2'b01, 1,  3, -1, -1,  1, 1'b0, 1'b0, 1);
        run_scn("verify_rsvd_mode",   3, 2'b11, 2'b00, 0, -1, -1, -1, -1, 1'b0, 1'b0, 2);

        for (int n = 0; n < 40; n++) begin
            ch   = int'($urandom_range(0, 3));
            md   = 2'($urandom);
            xt   = 2'($urandom);
            hdly = int'($urandom_range(0, 3));
            if (md == 2'b10 || $urandom_range(0, 1) == 1) tcp = int'($urandom_range(0, 3));
            else tcp = -1;
            if ($urandom_range(0, 3) == 0) eopp = int'($urandom_range(0, 3));
            else eopp = -1;
            dropp = int'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) hlp = int'($urandom_range(0, 3));
            else hlp = -1;
            ab = ($urandom_range(0, 7) == 0);
            run_scn("random", ch, md, xt, hdly, tcp, eopp, dropp, hlp, ab, 1'b0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
